// File: rtl/oam_dma_bus_ctrl_if.sv
// oam_dma_bus_ctrl_if: cpu, main-bus, high-bus and OAM-port signals of the OAM DMA bus controller
interface oam_dma_bus_ctrl_if;
  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        hi_rd_en;
  logic        hi_wr_en;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_wdata;
  logic [7:0]  hi_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;
  modport master (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, mem_rdata, hi_rdata,
    output cpu_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           hi_rd_en, hi_wr_en, hi_addr, hi_wdata, oam_we, oam_addr, oam_wdata, dma_active
  );
  modport slave (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, mem_rdata, hi_rdata,
    input  cpu_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           hi_rd_en, hi_wr_en, hi_addr, hi_wdata, oam_we, oam_addr, oam_wdata, dma_active
  );
endinterface

// File: rtl/oam_dma_bus_ctrl.sv
// oam_dma_bus_ctrl: splits cpu traffic onto main/high buses and runs the FF46 OAM DMA (ports: clk, rst, bus.master)
module oam_dma_bus_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          DMA_LEN      = 160
) (
  input logic                 clk,
  input logic                 rst,
  oam_dma_bus_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, START, XFER, FLUSH} state_t;
  state_t      state_q, state_d;
  logic [7:0]  dma_reg_q, dma_reg_d, idx_q, idx_d, pend_data_q, pend_data_d, pend_idx_q, pend_idx_d;
  logic        pend_valid_q, pend_valid_d;
  logic        is_reg, is_hi, is_main, reg_wr, active, xfer, last, main_rd, main_wr, hi_any;
  logic [7:0]  src;
  assign is_reg  = bus.cpu_addr == DMA_REG_ADDR;
  assign is_hi   = bus.cpu_addr[15:8] == 8'hFF && !is_reg;
  assign is_main = !is_hi && !is_reg;
  assign reg_wr  = bus.cpu_wr_en && is_reg;
  assign active  = state_q != IDLE;
  assign xfer    = state_q == XFER;
  assign last    = idx_q == 8'(DMA_LEN - 1);
  // sources E0-FF fold onto C0-DF, the echo of work RAM
  assign src     = dma_reg_q < 8'hE0 ? dma_reg_q : (dma_reg_q & 8'hDF);
  assign main_rd = bus.cpu_rd_en && is_main && !active;
  assign main_wr = bus.cpu_wr_en && is_main && !active;
  assign hi_any  = is_hi && (bus.cpu_rd_en || bus.cpu_wr_en);
  assign bus.hi_rd_en   = bus.cpu_rd_en && is_hi;
  assign bus.hi_wr_en   = bus.cpu_wr_en && is_hi;
  assign bus.hi_addr    = hi_any ? bus.cpu_addr[7:0] : 8'h00;
  assign bus.hi_wdata   = hi_any ? bus.cpu_wdata : 8'h00;
  assign bus.mem_rd_en  = xfer || main_rd;
  assign bus.mem_wr_en  = main_wr;
  assign bus.mem_addr   = xfer ? {src, idx_q} : (main_rd || main_wr) ? bus.cpu_addr : 16'h0000;
  assign bus.mem_wdata  = (main_rd || main_wr) ? bus.cpu_wdata : 8'h00;
  assign bus.cpu_rdata  = !bus.cpu_rd_en ? 8'h00 : is_reg ? dma_reg_q : is_hi ? bus.hi_rdata :
                          active ? 8'hFF : bus.mem_rdata;
  assign bus.oam_we     = pend_valid_q;
  assign bus.oam_addr   = pend_valid_q ? pend_idx_q : 8'h00;
  assign bus.oam_wdata  = pend_valid_q ? pend_data_q : 8'h00;
  assign bus.dma_active = active;
  always_comb begin
    state_d      = state_q;
    dma_reg_d    = dma_reg_q;
    idx_d        = idx_q;
    pend_data_d  = pend_data_q;
    pend_idx_d   = pend_idx_q;
    pend_valid_d = 1'b0;
    // a register write restarts the sequence from any state, dropping the in-flight byte
    if (reg_wr) begin
      state_d   = START;
      dma_reg_d = bus.cpu_wdata;
      idx_d     = 8'h00;
    end else if (state_q == START) begin
      state_d = XFER;
      idx_d   = 8'h00;
    end else if (xfer) begin
      pend_data_d  = bus.mem_rdata;
      pend_idx_d   = idx_q;
      pend_valid_d = 1'b1;
      idx_d        = idx_q + 8'd1;
      state_d      = last ? FLUSH : XFER;
    end else if (state_q == FLUSH) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dma_reg_q    <= 8'h00;
      idx_q        <= 8'h00;
      pend_data_q  <= 8'h00;
      pend_idx_q   <= 8'h00;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dma_reg_q    <= dma_reg_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_idx_q   <= pend_idx_d;
      pend_valid_q <= pend_valid_d;
    end
  end
endmodule

// File: tb/tb_oam_dma_bus_ctrl.sv
// tb_oam_dma_bus_ctrl: directed vector table plus multi-cycle DMA sequences for oam_dma_bus_ctrl
module tb_oam_dma_bus_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic mem_mode;
  logic [7:0] hi_val;
  int checks = 0;
  int failures = 0;
  oam_dma_bus_ctrl_if bus();
  oam_dma_bus_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem_mode ? 8'h5A : (bus.mem_addr[7:0] ^ 8'h3C);
  assign bus.hi_rdata  = hi_val;
  typedef struct {
    logic rd, wr; logic [15:0] addr; logic [7:0] wdata; logic mm;
    logic [7:0] e_rdata; logic e_mrd, e_mwr; logic [15:0] e_maddr; logic [7:0] e_mwd;
    logic e_hrd, e_hwr; logic [7:0] e_haddr, e_hwd;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_rd_en = r;
    bus.cpu_wr_en = w;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask
  task automatic run(input logic [7:0] s1, input logic [7:0] b1, input int rk, input logic [7:0] s2,
                     input logic [7:0] b2, input int xk, input bit cpu, input int exp_act, input int exp_oam);
    int t0, j, n_act, n_oam, kend;
    logic [7:0] b;
    bit on, mrd, owe;
    t0 = 0; b = b1; n_act = 0; n_oam = 0;
    kend = xk > 0 ? xk + 10 : rk > 0 ? rk + 163 : 163;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'hFF46, s1);
    #3;
    chk("trig_mem_wr", 16'(bus.mem_wr_en), 16'h0);
    chk("trig_hi_wr", 16'(bus.hi_wr_en), 16'h0);
    chk("trig_active", 16'(bus.dma_active), 16'h0);
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0000, 8'h00);
      if (cpu && k == 10) drive(1'b1, 1'b0, 16'h8000, 8'h00);
      if (cpu && k == 11) drive(1'b0, 1'b1, 16'hFF80, 8'h77);
      if (cpu && k == 12) drive(1'b1, 1'b0, 16'hFF90, 8'h00);
      if (cpu && k == 13) drive(1'b0, 1'b1, 16'h8000, 8'h55);
      if (k == rk) drive(1'b0, 1'b1, 16'hFF46, s2);
      if (k == xk) rst = 1'b1;
      if (xk > 0 && k == xk + 2) rst = 1'b0;
      #3;
      j = k - t0;
      on = !(xk > 0 && k > xk);
      mrd = on && j >= 2 && j <= 161;
      owe = on && j >= 3 && j <= 162;
      chk($sformatf("active k=%0d", k), 16'(bus.dma_active), 16'(on && j >= 1 && j <= 162));
      chk($sformatf("mem_rd k=%0d", k), 16'(bus.mem_rd_en), 16'(mrd));
      chk($sformatf("mem_addr k=%0d", k), bus.mem_addr, mrd ? {b, 8'(j - 2)} : 16'h0000);
      chk($sformatf("mem_wr k=%0d", k), 16'(bus.mem_wr_en), 16'h0);
      chk($sformatf("oam_we k=%0d", k), 16'(bus.oam_we), 16'(owe));
      chk($sformatf("oam_addr k=%0d", k), 16'(bus.oam_addr), owe ? 16'(j - 3) : 16'h0);
      chk($sformatf("oam_wdata k=%0d", k), 16'(bus.oam_wdata), owe ? 16'(8'(j - 3) ^ 8'h3C) : 16'h0);
      if (cpu && k == 10) chk("dma_rd_main", 16'(bus.cpu_rdata), 16'h00FF);
      else if (cpu && k == 11) begin
        chk("dma_hi_wr", 16'(bus.hi_wr_en), 16'h1);
        chk("dma_hi_addr", 16'(bus.hi_addr), 16'h0080);
        chk("dma_hi_wdata", 16'(bus.hi_wdata), 16'h0077);
      end else if (cpu && k == 12) begin
        chk("dma_hi_rd", 16'(bus.hi_rd_en), 16'h1);
        chk("dma_hi_rdata", 16'(bus.cpu_rdata), 16'h00AB);
      end else begin
        chk($sformatf("hi_rd k=%0d", k), 16'(bus.hi_rd_en), 16'h0);
        chk($sformatf("hi_wr k=%0d", k), 16'(bus.hi_wr_en), 16'h0);
      end
      n_act += int'(bus.dma_active);
      n_oam += int'(bus.oam_we);
      if (k == rk) begin
        t0 = rk;
        b  = b2;
      end
    end
    chk("active_cycles", 16'(n_act), 16'(exp_act));
    chk("oam_strobes", 16'(n_oam), 16'(exp_oam));
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'hFF46, 8'h00);
    #3;
    chk("reg_readback", 16'(bus.cpu_rdata), xk > 0 ? 16'h0 : 16'(rk > 0 ? s2 : s1));
    chk("reg_rd_no_mem", 16'(bus.mem_rd_en), 16'h0);
    chk("reg_rd_no_hi", 16'(bus.hi_rd_en), 16'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 16'hC123, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 16'hC123, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 16'h8000, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 16'h8000, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 16'hFF90, 8'h00, 1'b0, 8'hAB, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h90, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 16'hFF80, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 8'h80, 8'h77};
    vecs[5] = '{1'b0, 1'b0, 16'h1234, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 16'hFEFF, 8'h00, 1'b0, 8'hC3, 1'b1, 1'b0, 16'hFEFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 16'hFF00, 8'h00, 1'b0, 8'hAB, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
    rst = 1'b1;
    mem_mode = 1'b0;
    hi_val = 8'hAB;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) @(posedge clk);
    #4;
    chk("rst_active", 16'(bus.dma_active), 16'h0);
    chk("rst_oam_we", 16'(bus.oam_we), 16'h0);
    chk("rst_mem_rd", 16'(bus.mem_rd_en), 16'h0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_hi_addr", 16'(bus.hi_addr), 16'h0);
    chk("rst_cpu_rdata", 16'(bus.cpu_rdata), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      mem_mode = vecs[i].mm;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      #3;
      chk($sformatf("v%0d cpu_rdata", i), 16'(bus.cpu_rdata), 16'(vecs[i].e_rdata));
      chk($sformatf("v%0d mem_rd", i), 16'(bus.mem_rd_en), 16'(vecs[i].e_mrd));
      chk($sformatf("v%0d mem_wr", i), 16'(bus.mem_wr_en), 16'(vecs[i].e_mwr));
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d mem_wdata", i), 16'(bus.mem_wdata), 16'(vecs[i].e_mwd));
      chk($sformatf("v%0d hi_rd", i), 16'(bus.hi_rd_en), 16'(vecs[i].e_hrd));
      chk($sformatf("v%0d hi_wr", i), 16'(bus.hi_wr_en), 16'(vecs[i].e_hwr));
      chk($sformatf("v%0d hi_addr", i), 16'(bus.hi_addr), 16'(vecs[i].e_haddr));
      chk($sformatf("v%0d hi_wdata", i), 16'(bus.hi_wdata), 16'(vecs[i].e_hwd));
      chk($sformatf("v%0d oam_we", i), 16'(bus.oam_we), 16'h0);
      chk($sformatf("v%0d active", i), 16'(bus.dma_active), 16'h0);
    end
    @(posedge clk); #1;
    mem_mode = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    run(8'hC1, 8'hC1, 0, 8'h00, 8'h00, 0, 1'b1, 162, 160);
    run(8'hF2, 8'hD2, 0, 8'h00, 8'h00, 0, 1'b0, 162, 160);
    run(8'hDF, 8'hDF, 0, 8'h00, 8'h00, 0, 1'b0, 162, 160);
    run(8'hC0, 8'hC0, 50, 8'hC8, 8'hC8, 0, 1'b0, 212, 208);
    run(8'hC1, 8'hC1, 0, 8'h00, 8'h00, 80, 1'b0, 80, 78);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
